// File: rtl/register_bank_pkg.sv
// Shared types, sizes and helpers for the register bank.
package register_bank_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 4;
    localparam int NUM_REGS  = 15;
    localparam int NUM_WORDS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] PC_IDX = 4'd15;

    typedef logic [DATA_W-1:0] word_t;

    // One-hot write select for the stored registers; address 15 never selects
    // anything because the program counter lives outside the bank.
    function automatic logic [NUM_REGS-1:0] decodeWrite(
        input logic              we,
        input logic [ADDR_W-1:0] addr
    );
        logic [NUM_REGS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = we && (addr != PC_IDX) && (addr == ADDR_W'(i));
        end
        return sel;
    endfunction

endpackage

// File: rtl/register_bank_reg32_en.sv
// One 32-bit storage word with load enable and asynchronous active-low clear.
module reg32_en
    import register_bank_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  en_i,
    input  word_t d_i,
    output word_t q_o
);

    word_t data_q;
    word_t data_d;

    // Next value: load new data when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    // Storage flop; clear wins immediately, so writes are blocked during reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/register_bank.sv
// Register bank: R0..R14 stored, R15 supplied externally as the program counter.
// Two combinational read ports, one synchronous write port, no write bypass.
module register_bank
    import register_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic              WE3,
    input  word_t             WD3,
    input  word_t             R15,
    output word_t             RD1,
    output word_t             RD2
);

    logic [NUM_REGS-1:0] writeEn;
    word_t               regWords  [NUM_REGS];
    word_t               readWords [NUM_WORDS];

    // Write decoder: one-hot select of the target register, address 15 masked.
    always_comb begin
        writeEn = decodeWrite(WE3, A3);
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gen_regs
        reg32_en u_reg (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (writeEn[g]),
            .d_i    (WD3),
            .q_o    (regWords[g])
        );
    end

    // Read table: stored words in slots 0..14, the live PC input in slot 15.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            readWords[i] = regWords[i];
        end
        readWords[PC_IDX] = R15;
    end

    assign RD1 = readWords[A1];
    assign RD2 = readWords[A2];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank using an expected-value queue.
module tb_register_bank;
    import register_bank_pkg::*;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } expect_t;

    logic        clk;
    logic        rst;
    logic [3:0]  A1, A2, A3;
    logic        WE3;
    logic [31:0] WD3, R15;
    logic [31:0] RD1, RD2;

    logic [31:0] model [15];
    expect_t     sbQueue [$];
    int          testsRun;
    int          testsFailed;

    register_bank dut (
        .clk (clk),
        .rst (rst),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .WE3 (WE3),
        .WD3 (WD3),
        .R15 (R15),
        .RD1 (RD1),
        .RD2 (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write at the falling edge so it lands on the next rising edge.
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        A3  = addr;
        WD3 = data;
        WE3 = 1'b1;
        @(posedge clk);
        #1;
        WE3 = 1'b0;
        if (rst && addr != 4'd15) model[addr] = data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        A1 = 4'd0; A2 = 4'd1; A3 = 4'd0; WE3 = 1'b0; WD3 = '0; R15 = 32'h0000_0ABC;
        for (int i = 0; i < 15; i++) model[i] = '0;
        #2;
        testsRun++;
        if (RD1 !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_rd1: got %h want %h", RD1, 32'h0); end
        testsRun++;
        if (RD2 !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_rd2: got %h want %h", RD2, 32'h0); end
        A1 = 4'd15;
        #1;
        testsRun++;
        if (RD1 !== 32'h0000_0ABC) begin testsFailed++; $display("[TB] FAIL reset_pc: got %h want %h", RD1, 32'h0000_0ABC); end
        // Write attempt while held in reset must not stick.
        applyStimulus(4'd4, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b1;
        A1 = 4'd4;
        #1;
        testsRun++;
        if (RD1 !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_write_blocked: got %h want %h", RD1, 32'h0); end
    endtask

    task automatic test_basic_write();
        applyStimulus(4'd2, 32'h3E);
        A1 = 4'd2;
        #1;
        testsRun++;
        if (RD1 !== 32'h3E) begin testsFailed++; $display("[TB] FAIL basic_write: got %h want %h", RD1, 32'h3E); end
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (RD1 !== 32'h3E) begin testsFailed++; $display("[TB] FAIL basic_hold: got %h want %h", RD1, 32'h3E); end
    endtask

    task automatic test_r15_passthrough();
        R15 = 32'h0000_1000;
        A2 = 4'd15;
        #1;
        testsRun++;
        if (RD2 !== 32'h0000_1000) begin testsFailed++; $display("[TB] FAIL r15_first: got %h want %h", RD2, 32'h0000_1000); end
        R15 = 32'h0000_2004;
        #1;
        testsRun++;
        if (RD2 !== 32'h0000_2004) begin testsFailed++; $display("[TB] FAIL r15_follow: got %h want %h", RD2, 32'h0000_2004); end
    endtask

    task automatic test_write_pc_ignored();
        applyStimulus(4'd15, 32'hDEAD_BEEF);
        for (int i = 0; i < 15; i++) begin
            A1 = 4'(i);
            #1;
            testsRun++;
            if (RD1 !== model[i]) begin testsFailed++; $display("[TB] FAIL pc_write_r%0d: got %h want %h", i, RD1, model[i]); end
        end
        A1 = 4'd15;
        #1;
        testsRun++;
        if (RD1 !== R15) begin testsFailed++; $display("[TB] FAIL pc_write_read15: got %h want %h", RD1, R15); end
    endtask

    task automatic test_read_during_write();
        applyStimulus(4'd5, 32'h11);
        @(negedge clk);
        A1 = 4'd5; A2 = 4'd5;
        A3 = 4'd5; WD3 = 32'h22; WE3 = 1'b1;
        #1;
        testsRun++;
        if (RD1 !== 32'h11) begin testsFailed++; $display("[TB] FAIL rdw_before: got %h want %h", RD1, 32'h11); end
        @(posedge clk);
        #1;
        WE3 = 1'b0;
        model[5] = 32'h22;
        testsRun++;
        if (RD1 !== 32'h22) begin testsFailed++; $display("[TB] FAIL rdw_after: got %h want %h", RD1, 32'h22); end
        testsRun++;
        if (RD2 !== RD1 || RD2 !== 32'h22) begin testsFailed++; $display("[TB] FAIL rdw_port2: got %h want %h", RD2, 32'h22); end
    endtask

    task automatic test_all_regs();
        for (int i = 0; i < 15; i++) begin
            expect_t e;
            e.addr = 4'(i);
            e.data = 32'hC0DE_0000 | (32'(i) << 8) | 32'($urandom_range(0, 255));
            applyStimulus(e.addr, e.data);
            sbQueue.push_back(e);
        end
        while (sbQueue.size() > 0) begin
            expect_t e;
            e = sbQueue.pop_front();
            A1 = e.addr;
            A2 = 4'(14 - e.addr);
            #1;
            testsRun++;
            if (RD1 !== e.data) begin testsFailed++; $display("[TB] FAIL all_regs_r%0d: got %h want %h", e.addr, RD1, e.data); end
            testsRun++;
            if (RD2 !== model[14 - e.addr]) begin testsFailed++; $display("[TB] FAIL all_regs_port2_r%0d: got %h want %h", 14 - e.addr, RD2, model[14 - e.addr]); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        WE3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_t e;
            e.addr = 4'(i * 2);
            e.data = $urandom;
            A3 = e.addr;
            WD3 = e.data;
            sbQueue.push_back(e);
            @(negedge clk);
            model[e.addr] = e.data;
        end
        WE3 = 1'b0;
        while (sbQueue.size() > 0) begin
            expect_t e;
            e = sbQueue.pop_front();
            A1 = e.addr;
            A2 = e.addr;
            #1;
            testsRun++;
            if (RD1 !== e.data || RD2 !== e.data) begin
                testsFailed++;
                $display("[TB] FAIL b2b_r%0d: got %h/%h want %h", e.addr, RD1, RD2, e.data);
            end
        end
        A1 = 4'd1;
        #1;
        testsRun++;
        if (RD1 !== model[1]) begin testsFailed++; $display("[TB] FAIL b2b_neighbour: got %h want %h", RD1, model[1]); end
    endtask

    task automatic test_async_reset();
        applyStimulus(4'd3, 32'hA5A5_A5A5);
        A1 = 4'd3;
        #1;
        testsRun++;
        if (RD1 !== 32'hA5A5_A5A5) begin testsFailed++; $display("[TB] FAIL async_load: got %h want %h", RD1, 32'hA5A5_A5A5); end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        testsRun++;
        if (RD1 !== 32'h0) begin testsFailed++; $display("[TB] FAIL async_clear: got %h want %h", RD1, 32'h0); end
        for (int i = 0; i < 15; i++) model[i] = '0;
        applyStimulus(4'd3, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        testsRun++;
        if (RD1 !== 32'h0) begin testsFailed++; $display("[TB] FAIL async_write_blocked: got %h want %h", RD1, 32'h0); end
        // First write after release lands on the very next rising edge.
        A3 = 4'd7; WD3 = 32'h7777_0001; WE3 = 1'b1;
        @(posedge clk);
        #1;
        WE3 = 1'b0;
        A1 = 4'd7;
        #1;
        testsRun++;
        if (RD1 !== 32'h7777_0001) begin testsFailed++; $display("[TB] FAIL first_write_after_reset: got %h want %h", RD1, 32'h7777_0001); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        testsRun = 0;
        testsFailed = 0;
        test_reset();
        test_basic_write();
        test_r15_passthrough();
        test_write_pc_ignored();
        test_read_during_write();
        test_all_regs();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL have port `clk`: input, 1 bit, sole clock, rising-edge active.
REQ-003 The block SHALL have port `rst`: input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port `A1`: input, 4 bits, read port 1 register address.
REQ-005 The block SHALL have port `A2`: input, 4 bits, read port 2 register address.
REQ-006 The block SHALL have port `A3`: input, 4 bits, write port register address.
REQ-007 The block SHALL have port `WE3`: input, 1 bit, write enable for the write port.
REQ-008 The block SHALL have port `WD3`: input, 32 bits, write data.
REQ-009 The block SHALL have port `R15`: input, 32 bits, externally supplied program-counter value, returned when address 15 is read.
REQ-010 The block SHALL have port `RD1`: output, 32 bits, read data for `A1`.
REQ-011 The block SHALL have port `RD2`: output, 32 bits, read data for `A2`.

Function
REQ-012 The block SHALL hold 15 general registers, R0..R14, each 32 bits wide; R15 SHALL have no storage.
REQ-013 `RD1` SHALL be a combinational function of `A1`, with zero-cycle latency; the same rule SHALL apply to `RD2` and `A2`.
REQ-014 A read address of 0..14 SHALL return the stored register value.
REQ-015 A read address of 15 SHALL return the current `R15` input combinationally.
REQ-016 On a rising `clk` edge with `WE3`=1 and `A3` in 0..14, the block SHALL load `WD3` into R[`A3`].
REQ-017 A write with `A3`=15 SHALL be ignored, with no state change.
REQ-018 With `WE3`=0, all registers SHALL hold their values.
REQ-019 Read-during-write: a read of the register being written SHALL return the old value before the edge and the new value after the edge; there SHALL be no write-to-read bypass.
REQ-020 Both read ports SHALL be independent; `A1`=`A2` SHALL return identical data on both ports.
REQ-021 A write SHALL affect only register R[`A3`]; all other registers SHALL be unchanged.
REQ-022 Output values SHALL be fully defined for all 16 address codes, with no X for any address.

Reset
REQ-023 While `rst`=0, R0..R14 SHALL be cleared to 32'h0 immediately, independent of `clk`.
REQ-024 During reset, writes SHALL be blocked.
REQ-025 During reset, `RD1`/`RD2` SHALL read 0 for addresses 0..14 and `R15` for address 15.
REQ-026 Reset asserted mid-operation SHALL discard all stored values.
REQ-027 The first write after `rst` returns to 1 SHALL take effect on the next rising edge of `clk`.

Structure
REQ-028 A shared package SHALL define:
- DATA_W=32
- ADDR_W=4
- NUM_REGS=15
- PC_IDX=4'd15
- a 32-bit word typedef
REQ-029 One sub-module, `reg32_en`, SHALL be used: a 32-bit flop with async active-low clear and load enable.
REQ-030 The top level SHALL instantiate `reg32_en` 15 times, once per register.
REQ-031 The top level SHALL contain a one-hot write decoder that masks address 15, plus two 16:1 read muxes.
REQ-032 The design SHALL contain no latches, and all state SHALL be in `reg32_en`.

Verification
REQ-033 Reset clears storage: `rst`=0 with `A1`=0, `A2`=1 -> `RD1`=0 and `RD2`=0.
REQ-034 Basic write/read: `rst`=1, `WE3`=1, `A3`=2, `WD3`=32'h3E, rising edge, then `A1`=2 -> `RD1`=32'h3E; after `WE3`=0 and further edges -> still 32'h3E.
REQ-035 R15 passthrough: `R15`=32'h0000_1000, `A2`=15 -> `RD2`=32'h0000_1000; changing `R15` to 32'h2004 -> `RD2` follows in the same cycle.
REQ-036 Ignored write to address 15: `WE3`=1, `A3`=15, `WD3`=32'hDEAD_BEEF, rising edge -> R0..R14 unchanged and `RD1`(`A1`=15) equals the `R15` input.
REQ-037 Read-during-write: R5=32'h11, `A1`=5, `WE3`=1, `A3`=5, `WD3`=32'h22 -> `RD1`=32'h11 before the edge and 32'h22 after the edge; `A2`=5 -> `RD2` matches `RD1`.
REQ-038 Asynchronous reset: load R3=32'hA5A5_A5A5, then assert `rst`=0 between clock edges -> `RD1`(`A1`=3)=0 immediately; a write attempted during reset -> no effect.
